// File: rtl/multi_port_reg_file_if.sv
// multi_port_reg_file_if: read/write/clear bus for multi_port_reg_file.
interface multi_port_reg_file_if #(parameter int DATA_W = 32, parameter int ADDR_W = 2);
    logic [ADDR_W-1:0] read_register1, read_register2, write_register;
    logic [DATA_W-1:0] write_data, read_data1, read_data2;
    logic reg_write, clear_req, busy, clear_done;
    modport master (
        output read_register1, read_register2, write_register, write_data, reg_write, clear_req,
        input  read_data1, read_data2, busy, clear_done
    );
    modport slave (
        input  read_register1, read_register2, write_register, write_data, reg_write, clear_req,
        output read_data1, read_data2, busy, clear_done
    );
endinterface

// File: rtl/multi_port_reg_file.sv
// multi_port_reg_file: 2-read/1-write register file with synchronous reads and a bulk-clear sweep.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to matching read ports.
module multi_port_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input logic clk,
    input logic rst_n,
    multi_port_reg_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
    state_t state;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] cnt;
    logic wr_en, fwd1, fwd2;
    assign wr_en = bus.reg_write && bus.write_register != '0;
`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wr_en && bus.read_register1 == bus.write_register;
    assign fwd2 = wr_en && bus.read_register2 == bus.write_register;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            bus.read_data1 <= '0;
            bus.read_data2 <= '0;
            bus.busy <= 1'b0;
            bus.clear_done <= 1'b0;
            state <= IDLE;
            cnt <= ADDR_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    bus.read_data1 <= fwd1 ? bus.write_data : regs[bus.read_register1];
                    bus.read_data2 <= fwd2 ? bus.write_data : regs[bus.read_register2];
                    if (wr_en) regs[bus.write_register] <= bus.write_data;
                    if (bus.clear_req) begin
                        state <= CLEAR;
                        bus.busy <= 1'b1;
                        cnt <= ADDR_W'(1);
                    end
                end
                CLEAR: begin
                    bus.read_data1 <= '0;
                    bus.read_data2 <= '0;
                    regs[cnt] <= '0;
                    // all-ones counter marks the last index; reload instead of wrapping to 0
                    if (&cnt) begin
                        state <= DONE;
                        bus.busy <= 1'b0;
                        bus.clear_done <= 1'b1;
                        cnt <= ADDR_W'(1);
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    bus.read_data1 <= regs[bus.read_register1];
                    bus.read_data2 <= regs[bus.read_register2];
                    bus.clear_done <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multi_port_reg_file.sv
// tb_multi_port_reg_file: random + directed checks against a behavioural register-file model.
module tb_multi_port_reg_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    multi_port_reg_file_if #(.DATA_W(32), .ADDR_W(2)) bus ();
    multi_port_reg_file #(.DATA_W(32), .ADDR_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'hA5A5A5A5;
`else
    localparam logic [31:0] BYP_EXP = 32'h00000001;
`endif
    logic [31:0] mem [4];
    logic [31:0] exp_rd1 = 0, exp_rd2 = 0;
    logic exp_busy = 0, exp_done = 0;
    int sweep = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int ra);
`ifdef REGFILE_BYPASS_EN
        if (bus.reg_write && bus.write_register != 0 && ra == int'(bus.write_register)) return bus.write_data;
`endif
        return mem[ra];
    endfunction

    // reference model: sweep==0 means no clear in progress, otherwise the next index to zero
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] = 0;
            exp_rd1 = 0; exp_rd2 = 0; exp_busy = 0; exp_done = 0; sweep = 0;
        end else if (sweep != 0) begin
            exp_rd1 = 0; exp_rd2 = 0;
            mem[sweep] = 0;
            if (sweep == 3) begin
                sweep = 0; exp_busy = 0; exp_done = 1;
            end else sweep++;
        end else if (exp_done) begin
            exp_rd1 = mem[bus.read_register1];
            exp_rd2 = mem[bus.read_register2];
            exp_done = 0;
        end else begin
            exp_rd1 = model_read(int'(bus.read_register1));
            exp_rd2 = model_read(int'(bus.read_register2));
            if (bus.reg_write && bus.write_register != 0) mem[bus.write_register] = bus.write_data;
            if (bus.clear_req) begin
                sweep = 1; exp_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_rd1", bus.read_data1, exp_rd1);
            chk("model_rd2", bus.read_data2, exp_rd2);
            chk("model_busy", 32'(bus.busy), 32'(exp_busy));
            chk("model_done", 32'(bus.clear_done), 32'(exp_done));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.reg_write = 1; bus.write_register = a; bus.write_data = d;
        step();
        bus.reg_write = 0;
    endtask

    task automatic rd(input logic [1:0] a1, input logic [1:0] a2);
        bus.read_register1 = a1; bus.read_register2 = a2;
        step();
    endtask

    task automatic start_clear();
        bus.clear_req = 1;
        step();
        bus.clear_req = 0;
    endtask

    initial begin
        int n;
        bus.read_register1 = 0; bus.read_register2 = 0; bus.write_register = 0;
        bus.write_data = 0; bus.reg_write = 0; bus.clear_req = 0;
        #1 chk("reset_rd1", bus.read_data1, 0);
        chk("reset_busy", 32'(bus.busy), 0);
        #11 rst_n = 1;
        @(negedge clk);
        wr(2, 32'hDEADBEEF);
        rd(2, 0);
        chk("rd1_reg2", bus.read_data1, 32'hDEADBEEF);
        chk("rd2_reg0", bus.read_data2, 0);
        wr(0, 32'h12345678);
        rd(0, 0);
        chk("reg0_zero", bus.read_data1, 0);
        rd(2, 2);
        chk("same_addr", bus.read_data2, 32'hDEADBEEF);
        #2 rst_n = 0;
        #1 chk("async_rd1", bus.read_data1, 0);
        chk("async_rd2", bus.read_data2, 0);
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_done", 32'(bus.clear_done), 0);
        #1 rst_n = 1;
        @(negedge clk);
        wr(3, 32'h1);
        bus.read_register1 = 3;
        wr(3, 32'hA5A5A5A5);
        chk("bypass", bus.read_data1, BYP_EXP);
        wr(1, 32'h11); wr(2, 32'h22); wr(3, 32'h33);
        start_clear();
        n = 0;
        while (bus.busy && n < 10) begin
            n++;
            if (n == 2) begin
                bus.reg_write = 1; bus.write_register = 1; bus.write_data = 32'h77;
            end
            step();
            bus.reg_write = 0;
        end
        chk("busy_cycles", 32'(n), 3);
        chk("done_pulse", 32'(bus.clear_done), 1);
        step();
        chk("done_fall", 32'(bus.clear_done), 0);
        for (int a = 1; a < 4; a++) begin
            rd(2'(a), 2'(a));
            chk("cleared", bus.read_data1, 0);
        end
        wr(2, 32'h55);
        start_clear();
        step();
        #2 rst_n = 0;
        #1 chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.clear_done), 0);
        #1 rst_n = 1;
        @(negedge clk);
        wr(2, 32'hCAFEF00D);
        rd(2, 1);
        chk("post_abort_wr", bus.read_data1, 32'hCAFEF00D);
        chk("post_abort_rd", bus.read_data2, 0);
        for (int i = 0; i < 400; i++) begin
            bus.read_register1 = 2'($urandom);
            bus.read_register2 = 2'($urandom);
            bus.write_register = 2'($urandom);
            bus.write_data = $urandom;
            bus.reg_write = 1'($urandom);
            bus.clear_req = ($urandom_range(0, 15) == 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_port_reg_file.md
MULTI_PORT_REG_FILE -- requirements
Module: multi_port_reg_file

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data width in bits (>= 1).
REQ-002 Parameter ADDR_W, default 2, SHALL set the address width; DEPTH = 2**ADDR_W registers (ADDR_W >= 1).
REQ-003 Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 ReadRegister1  input  ADDR_W  SHALL be the read port 1 address.
REQ-006 ReadRegister2  input  ADDR_W  SHALL be the read port 2 address.
REQ-007 WriteRegister  input  ADDR_W  SHALL be the write address.
REQ-008 WriteData  input  DATA_W  SHALL be the write data.
REQ-009 RegWrite  input  1  SHALL be the write enable, sampled on the rising edge of Clk.
REQ-010 ClearReq  input  1  SHALL be the request to start a bulk-clear sweep, sampled on the rising edge of Clk.
REQ-011 ReadData1  output  DATA_W  SHALL be the registered read data for port 1.
REQ-012 ReadData2  output  DATA_W  SHALL be the registered read data for port 2.
REQ-013 Busy  output  1  SHALL be high while the clear sweep is in progress.
REQ-014 ClearDone  output  1  SHALL be a one-cycle pulse when the sweep completes.

Function
REQ-015 Register 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-016 Reads SHALL be synchronous: ReadDataN SHALL show Registers[ReadRegisterN] as sampled at edge k, valid after edge k (1-cycle latency).
REQ-017 Both read ports SHALL operate independently; both ports may use the same address in the same cycle.
REQ-018 In IDLE, a write SHALL occur at edge k when RegWrite=1 and WriteRegister!=0.
REQ-019 The FSM SHALL have three states: IDLE, CLEAR, DONE.
REQ-020 Transitions:
- IDLE->CLEAR when ClearReq=1.
- CLEAR->DONE after the register at index DEPTH-1 is zeroed.
- DONE->IDLE unconditionally on the next edge.
REQ-021 In CLEAR, a sweep counter SHALL start at 1 and zero one register per cycle, incrementing by 1; the sweep SHALL last exactly DEPTH-1 cycles.
REQ-022 Busy SHALL equal 1 exactly in CLEAR; ClearDone SHALL equal 1 exactly in DONE.
REQ-023 RegWrite SHALL be ignored (write dropped) in CLEAR and DONE.
REQ-024 ClearReq SHALL be ignored in CLEAR and DONE; no queuing or restart.
REQ-025 ReadData1 and ReadData2 SHALL register zero for reads sampled in CLEAR.
REQ-026 ClearReq=1 and RegWrite=1 together in IDLE:
- The write SHALL complete at that edge.
- The sweep SHALL then zero that register.
REQ-027 The counter SHALL be ADDR_W bits wide; completion SHALL be detected at value DEPTH-1, with no wrap-around write to index 0.

Reset
REQ-028 Rst_n=0 SHALL immediately force all of the following, independent of Clk:
- all registers to 0;
- ReadData1, ReadData2, Busy and ClearDone to 0;
- the FSM to IDLE and the sweep counter to 1.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep; ClearDone SHALL NOT pulse.
REQ-030 After deassertion, the first active edge SHALL behave as IDLE.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
- Defined: in IDLE, when RegWrite=1, WriteRegister!=0 and ReadRegisterN==WriteRegister at the same edge, ReadDataN SHALL capture WriteData.
- Undefined: ReadDataN SHALL capture the pre-write register value.
REQ-032 Forwarding SHALL never apply to address 0, or in CLEAR or DONE.

Verification (DATA_W=32, ADDR_W=2)
REQ-033 Reset with Rst_n=0 in mid-cycle -> ReadData1/2=0, Busy=0 and ClearDone=0 with no clock edge.
REQ-034 Write 0xDEADBEEF to reg 2; read reg 2 on port 1 and reg 0 on port 2 the next cycle -> ReadData1=0xDEADBEEF, ReadData2=0 one cycle later; a write of 0x12345678 to reg 0 leaves reg 0 reading 0.
REQ-035 Same-edge write of 0xA5A5A5A5 to reg 3 while reading reg 3 (reg 3 previously 0x1) -> ReadData1=0xA5A5A5A5 with REGFILE_BYPASS_EN defined, 0x00000001 without.
REQ-036 Fill regs 1-3 with 0x11, 0x22, 0x33, then pulse ClearReq -> Busy high for exactly 3 cycles, then ClearDone high for 1 cycle; regs 1-3 subsequently read 0.
REQ-037 RegWrite of 0x77 to reg 1 during the second CLEAR cycle -> write dropped; reg 1 reads 0 after DONE.
REQ-038 Rst_n asserted during the second CLEAR cycle -> Busy falls immediately, ClearDone never pulses, all registers read 0, and normal writes work on the first edge after deassertion.
